sr_bank_scheduler: RTL and testbench

- Shares a bank of NBITS gated SR flip-flops between NREQ requesters.
- Each requester issues set, reset, toggle or no-op commands addressed to a single flip-flop.
- The scheduler grants round-robin and drives registered, width-controlled S/R pulses.
- It guarantees S and R are never high together, which removes the illegal SR input state at the source.

---
 rtl/sr_sched_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/sr_bank_scheduler.sv | 151 +++++++++++++++
 tb/tb_sr_bank_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR bank scheduler.
// Holds the requester op encodings, the scheduler state encodings and
// a constant clog2 helper used to size index, grant and counter fields.
package sr_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_SET = 2'b01,
    OP_RST = 2'b10,
    OP_TGL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  // Ceiling log2; callers only pass values >= 2, so the result is >= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Ports:
//   req    - NREQ request vector
//   ptr    - requester with highest priority this cycle
//   grant  - one-hot grant (zero when no request)
//   winner - binary index of the granted requester (0 when no request)
module rr_arbiter
  import sr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [GW-1:0]   winner
);

  // Walk the requesters starting at ptr and wrapping; the first asserted one wins.
  always_comb begin : arb
    int c;
    logic found;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    c      = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        winner   = GW'(c);
      end
    end
  end

endmodule

// File: rtl/sr_bank_scheduler.sv
// Shares a bank of NBITS gated SR flip-flops between NREQ requesters.
// Each accepted command produces a registered, PULSE_CYC-wide pulse on a
// single S or R line, followed by GAP_CYC all-low cycles; S and R are never
// driven high together.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - per-requester handshake, ready is one-hot and combinational
//   req_op, req_idx     - per-requester op (2 bits) and flip-flop index (IDXW bits)
//   q_in                - Q feedback from the bank, used to resolve toggles
//   s_out, r_out        - S/R drive to the bank
//   busy, grant_id      - scheduler activity and requester being served
//   done, err           - completion pulse, and out-of-range index flag with it
module sr_bank_scheduler
  import sr_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NBITS     = 8,
  parameter int IDXW      = clog2(NBITS),
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [IDXW*NREQ-1:0]     req_idx,
  input  logic [NBITS-1:0]         q_in,
  output logic [NBITS-1:0]         s_out,
  output logic [NBITS-1:0]         r_out,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     done,
  output logic                     err
);

  localparam int GW   = clog2(NREQ);
  localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW   = clog2(CMAX + 1);

  state_t            state;
  logic [GW-1:0]     rr_ptr;
  logic [CW-1:0]     cnt;
  logic              oor;

  logic [NREQ-1:0]   grant;
  logic [GW-1:0]     winner;
  op_t               win_op;
  logic [IDXW-1:0]   win_idx;
  logic              win_in_range;
  logic [NBITS-1:0]  win_bit;
  logic              tgl_q;
  logic              do_set;
  logic              do_rst;

  rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  // Accept strobe only exists in IDLE and is suppressed while reset is held.
  assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;

  // Decode the winning requester's command into a one-hot S or R drive.
  // Toggles are resolved against q_in in the accept cycle itself.
  always_comb begin
    win_op       = op_t'(req_op[2*int'(winner) +: 2]);
    win_idx      = req_idx[IDXW*int'(winner) +: IDXW];
    win_in_range = (int'(win_idx) < NBITS);
    win_bit      = '0;
    tgl_q        = 1'b0;
    if (win_in_range) begin
      win_bit[win_idx] = 1'b1;
      tgl_q            = q_in[win_idx];
    end
    do_set = 1'b0;
    do_rst = 1'b0;
    case (win_op)
      OP_SET:  do_set = win_in_range;
      OP_RST:  do_rst = win_in_range;
      OP_TGL:  begin
        do_set = win_in_range && !tgl_q;
        do_rst = win_in_range &&  tgl_q;
      end
      default: ;
    endcase
  end

  // IDLE -> PULSE -> GAP -> IDLE. The pulse pattern is registered at accept
  // and simply held through PULSE, so later input changes cannot disturb it.
  // done/err are registered one cycle ahead so they land on the last GAP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      s_out    <= '0;
      r_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      oor      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (|req_valid) begin
            state    <= ST_PULSE;
            busy     <= 1'b1;
            grant_id <= winner;
            rr_ptr   <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            cnt      <= CW'(PULSE_CYC - 1);
            s_out    <= do_set ? win_bit : '0;
            r_out    <= do_rst ? win_bit : '0;
            oor      <= !win_in_range;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            state <= ST_GAP;
            s_out <= '0;
            r_out <= '0;
            cnt   <= CW'(GAP_CYC - 1);
            done  <= (GAP_CYC == 1);
            err   <= (GAP_CYC == 1) && oor;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
          end else begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1));
            err  <= (cnt == CW'(1)) && oor;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_scheduler.sv
// Self-checking bench for sr_bank_scheduler (NREQ=4, NBITS=8, PULSE_CYC=2,
// GAP_CYC=1) plus a second NBITS=12 copy whose index field can exceed the bank.
module tb_sr_bank_scheduler;

  localparam int P = 2;
  localparam int G = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [7:0]  req_op    = '0;
  logic [11:0] req_idx   = '0;
  logic [7:0]  q_in      = '0;
  logic [7:0]  s_out, r_out;
  logic        busy, done, err;
  logic [1:0]  grant_id;

  logic [3:0]  v2   = '0;
  logic [3:0]  rdy2;
  logic [7:0]  op2  = '0;
  logic [15:0] idx2 = '0;
  logic [11:0] q2   = '0;
  logic [11:0] s2, r2;
  logic        busy2, done2, err2;
  logic [1:0]  gid2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_bank_scheduler #(.NREQ(4), .NBITS(8), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_idx(req_idx), .q_in(q_in), .s_out(s_out), .r_out(r_out),
    .busy(busy), .grant_id(grant_id), .done(done), .err(err)
  );

  sr_bank_scheduler #(.NREQ(4), .NBITS(12), .PULSE_CYC(P), .GAP_CYC(G)) dut12 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
    .req_op(op2), .req_idx(idx2), .q_in(q2), .s_out(s2), .r_out(r2),
    .busy(busy2), .grant_id(gid2), .done(done2), .err(err2)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  op;
    logic [11:0] idx;
    logic [7:0]  q;
    logic [3:0]  ready;
    logic [7:0]  s;
    logic [7:0]  r;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[14];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [7:0] op,
                               input logic [11:0] idx, input logic [7:0] q);
    req_valid = v;
    req_op    = op;
    req_idx   = idx;
    q_in      = q;
    #1;
  endtask

  task automatic applyStimulusB(input logic [3:0] v, input logic [7:0] op, input logic [15:0] idx);
    v2   = v;
    op2  = op;
    idx2 = idx;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    v2        = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] rrPick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++)
      if (v[(ptr + k) % 4]) return 4'((ptr + k) % 4);
    return 4'd0;
  endfunction

  // Reference model state for the randomised phase: everything is derived
  // from the cycle number of the last accept.
  int          mPtr, mNextFree, mAccT, mWin, accepts, dones;
  logic [7:0]  mS, mR;
  logic [3:0]  expReady, v;
  logic [7:0]  op, q;
  logic [11:0] idx;
  logic [1:0]  o;
  int          w, ix;

  initial begin
    tbl[0]  = '{4'h1, 8'h01, 12'h003, 8'h00, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{4'h0, 8'hAA, 12'hFFF, 8'h00, 4'h0, 8'h08, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{4'h0, 8'h00, 12'h000, 8'h00, 4'h0, 8'h08, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{4'h0, 8'h00, 12'h000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[4]  = '{4'h0, 8'h00, 12'h000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{4'h1, 8'h03, 12'h005, 8'h20, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{4'h0, 8'h55, 12'h000, 8'h20, 4'h0, 8'h00, 8'h20, 1'b1, 1'b0};
    tbl[7]  = '{4'h0, 8'h00, 12'h000, 8'h20, 4'h0, 8'h00, 8'h20, 1'b1, 1'b0};
    tbl[8]  = '{4'h0, 8'h00, 12'h000, 8'h20, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[9]  = '{4'h1, 8'h03, 12'h005, 8'h00, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{4'h0, 8'hAA, 12'h007, 8'hFF, 4'h0, 8'h20, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{4'h0, 8'h00, 12'h000, 8'h00, 4'h0, 8'h20, 8'h00, 1'b1, 1'b0};
    tbl[12] = '{4'h0, 8'h00, 12'h000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[13] = '{4'h0, 8'h00, 12'h000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};

    // Reset state, then set idx 3 and two toggles on idx 5 from the table
    doReset();
    checkOutput("reset.s_out", s_out, 0);
    checkOutput("reset.r_out", r_out, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.err", err, 0);
    checkOutput("reset.grant_id", grant_id, 0);
    checkOutput("reset.req_ready", req_ready, 0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tbl%0d.s_out", k), s_out, tbl[k].s);
      checkOutput($sformatf("tbl%0d.r_out", k), r_out, tbl[k].r);
      checkOutput($sformatf("tbl%0d.busy", k), busy, tbl[k].busy);
      checkOutput($sformatf("tbl%0d.done", k), done, tbl[k].done);
      checkOutput($sformatf("tbl%0d.err", k), err, 0);
      checkOutput($sformatf("tbl%0d.grant_id", k), grant_id, 0);
      applyStimulus(tbl[k].valid, tbl[k].op, tbl[k].idx, tbl[k].q);
      checkOutput($sformatf("tbl%0d.req_ready", k), req_ready, tbl[k].ready);
    end

    // All four requesters hold reset commands to idx 0..3: grants rotate 0,1,2,3,0
    doReset();
    for (int c = 0; c < 20; c++) begin
      int k, ph;
      k  = c / 4;
      ph = c % 4;
      @(negedge clk);
      checkOutput($sformatf("rr%0d.r_out", c), r_out, (ph == 1 || ph == 2) ? (8'h01 << (k % 4)) : 8'h00);
      checkOutput($sformatf("rr%0d.s_out", c), s_out, 0);
      checkOutput($sformatf("rr%0d.done", c), done, ph == 3);
      checkOutput($sformatf("rr%0d.busy", c), busy, ph != 0);
      checkOutput($sformatf("rr%0d.grant_id", c), grant_id, (c == 0) ? 0 : (ph == 0 ? (k - 1) % 4 : k % 4));
      applyStimulus(4'hF, 8'hAA, 12'h688, 8'h00);
      checkOutput($sformatf("rr%0d.req_ready", c), req_ready, (ph == 0) ? (4'h1 << (k % 4)) : 4'h0);
    end

    // Out-of-range index on the 12-bit bank, then an in-range set of bit 11
    doReset();
    applyStimulus(4'h0, 8'h00, 12'h000, 8'h00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("oor%0d.s_out", c), s2, (c == 6 || c == 7) ? 12'h800 : 12'h000);
      checkOutput($sformatf("oor%0d.r_out", c), r2, 0);
      checkOutput($sformatf("oor%0d.done", c), done2, (c == 3 || c == 8));
      checkOutput($sformatf("oor%0d.err", c), err2, c == 3);
      checkOutput($sformatf("oor%0d.busy", c), busy2, (c >= 1 && c <= 3) || (c >= 6 && c <= 8));
      checkOutput($sformatf("oor%0d.grant_id", c), gid2, (c >= 1) ? 2 : 0);
      if (c == 0)      applyStimulusB(4'h4, 8'h10, 16'h0D00);
      else if (c == 5) applyStimulusB(4'h4, 8'h10, 16'h0B00);
      else             applyStimulusB(4'h0, 8'h00, 16'h0000);
      checkOutput($sformatf("oor%0d.req_ready", c), rdy2, (c == 0 || c == 5) ? 4'h4 : 4'h0);
    end

    // Reset during the first PULSE cycle drops the command and the RR pointer
    doReset();
    @(negedge clk);
    applyStimulus(4'hF, 8'h55, 12'h688, 8'h00);
    checkOutput("midrst.accept", req_ready, 4'h1);
    @(negedge clk);
    checkOutput("midrst.pulse", s_out, 8'h01);
    rst = 1'b1;
    applyStimulus(4'hF, 8'h55, 12'h688, 8'h00);
    checkOutput("midrst.ready_in_rst", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst.s_out", s_out, 0);
    checkOutput("midrst.r_out", r_out, 0);
    checkOutput("midrst.busy", busy, 0);
    applyStimulus(4'h0, 8'h00, 12'h000, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst%0d.no_done", c), done, 0);
    end
    applyStimulus(4'hF, 8'h55, 12'h688, 8'h00);
    checkOutput("midrst.ptr_restart", req_ready, 4'h1);
    @(negedge clk);
    checkOutput("midrst.grant_id", grant_id, 0);
    checkOutput("midrst.s_again", s_out, 8'h01);

    // Randomised traffic against a timestamp-based model
    doReset();
    mPtr = 0; mNextFree = 0; mAccT = -1000; mWin = 0; accepts = 0; dones = 0;
    mS = '0; mR = '0;
    for (int c = 0; c < 10006; c++) begin
      logic inPulse, inBusy, isDone;
      @(negedge clk);
      inPulse = (c >= mAccT + 1) && (c <= mAccT + P);
      inBusy  = (c >= mAccT + 1) && (c <= mAccT + P + G);
      isDone  = (c == mAccT + P + G);
      checkOutput($sformatf("rnd%0d.s_out", c), s_out, inPulse ? mS : 8'h00);
      checkOutput($sformatf("rnd%0d.r_out", c), r_out, inPulse ? mR : 8'h00);
      checkOutput($sformatf("rnd%0d.busy", c), busy, inBusy);
      checkOutput($sformatf("rnd%0d.done", c), done, isDone);
      checkOutput($sformatf("rnd%0d.err", c), err, 0);
      checkOutput($sformatf("rnd%0d.grant_id", c), grant_id, mWin);
      checkOutput($sformatf("rnd%0d.sr_overlap", c), s_out & r_out, 0);
      checkOutput($sformatf("rnd%0d.one_hot", c), $countones(s_out | r_out) <= 1, 1);
      if (done) dones++;
      if (c < 10000) begin
        v   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        op  = 8'($urandom);
        idx = 12'($urandom);
        q   = 8'($urandom);
      end else begin
        v = 4'h0; op = 8'h00; idx = 12'h000; q = 8'h00;
      end
      applyStimulus(v, op, idx, q);
      expReady = 4'h0;
      if (c >= mNextFree && v != 4'h0) begin
        w        = int'(rrPick(v, mPtr));
        expReady = 4'h1 << w;
        o        = op[2*w +: 2];
        ix       = int'(idx[3*w +: 3]);
        mS       = '0;
        mR       = '0;
        if (o == 2'b01 || (o == 2'b11 && !q[ix])) mS[ix] = 1'b1;
        if (o == 2'b10 || (o == 2'b11 &&  q[ix])) mR[ix] = 1'b1;
        mAccT     = c;
        mNextFree = c + P + G + 1;
        mPtr      = (w + 1) % 4;
        mWin      = w;
        accepts++;
      end
      checkOutput($sformatf("rnd%0d.req_ready", c), req_ready, expReady);
    end
    checkOutput("rnd.accepts_vs_dones", dones, accepts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
